// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution block family.
package conv_pkg;

    localparam int unsigned DefBits       = 9;
    localparam int unsigned DefKernelSize = 3;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoadK,
        StStream,
        StDrain,
        StFinish
    } seq_state_e;

    // Ceiling log2, never below 1 so that every counter keeps at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Front-end and datapath signal bundle of the frame sequencer.
interface conv_frame_sequencer_if
    import conv_pkg::*;
#(
    parameter int unsigned BITS       = DefBits,
    parameter int unsigned IMG_LENGTH = 128,
    parameter int unsigned IMG_HEIGHT = 128
);
    localparam int unsigned RowW = clog2(IMG_HEIGHT);
    localparam int unsigned ColW = clog2(IMG_LENGTH);

    logic            start;
    logic            kernel_reload;
    logic            coef_valid;
    logic [BITS-1:0] coef_data;
    logic            coef_ready;
    logic            pix_valid;
    logic [BITS-1:0] pix_data;
    logic            pix_ready;
    logic            dp_reset;
    logic            dp_kernel_we;
    logic [BITS-1:0] dp_kernel_in;
    logic            dp_shift_we;
    logic [BITS-1:0] dp_img_in;
    logic [BITS-1:0] dp_pixel;
    logic            out_valid;
    logic [BITS-1:0] out_pixel;
    logic [RowW-1:0] out_row;
    logic [ColW-1:0] out_col;
    logic            busy;
    logic            done;
    logic            kernel_loaded;

    modport master (
        output start, kernel_reload, coef_valid, coef_data, pix_valid, pix_data, dp_pixel,
        input  coef_ready, pix_ready, dp_reset, dp_kernel_we, dp_kernel_in, dp_shift_we,
               dp_img_in, out_valid, out_pixel, out_row, out_col, busy, done, kernel_loaded
    );

    modport slave (
        input  start, kernel_reload, coef_valid, coef_data, pix_valid, pix_data, dp_pixel,
        output coef_ready, pix_ready, dp_reset, dp_kernel_we, dp_kernel_in, dp_shift_we,
               dp_img_in, out_valid, out_pixel, out_row, out_col, busy, done, kernel_loaded
    );

endinterface

// File: rtl/conv_tag_pipe.sv
// Delay line carrying the window-valid flag and centre coordinates alongside the datapath.
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int unsigned Depth = 1,
    parameter int unsigned RowW  = 7,
    parameter int unsigned ColW  = 7
) (
    input  logic            clk_i,
    input  logic            clr_i,
    input  logic            vld_i,
    input  logic [RowW-1:0] row_i,
    input  logic [ColW-1:0] col_i,
    output logic            vld_o,
    output logic [RowW-1:0] row_o,
    output logic [ColW-1:0] col_o
);

    logic [Depth-1:0] vld_q;
    logic [RowW-1:0]  row_q [Depth];
    logic [ColW-1:0]  col_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            vld_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            row_q[0] <= row_i;
            col_q[0] <= col_i;
            for (int i = 1; i < Depth; i++) begin
                vld_q[i] <= vld_q[i-1];
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[Depth-1];
    assign row_o = row_q[Depth-1];
    assign col_o = col_q[Depth-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 3x3 convolution datapath: kernel load, pixel streaming, window tagging.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned BITS        = DefBits,
    parameter int unsigned KERNEL_SIZE = DefKernelSize,
    parameter int unsigned IMG_LENGTH  = 128,
    parameter int unsigned IMG_HEIGHT  = 128,
    parameter int unsigned DP_LAT      = 1
) (
    input logic                   clk_i,
    input logic                   reset_i,
    conv_frame_sequencer_if.slave bus
);

    localparam int unsigned NumCoef = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned RowW    = clog2(IMG_HEIGHT);
    localparam int unsigned ColW    = clog2(IMG_LENGTH);
    localparam int unsigned KW      = clog2(NumCoef);
    localparam int unsigned DW      = clog2(DP_LAT + 2);

    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_LENGTH - 1);
    localparam logic [RowW-1:0] RowMin  = RowW'(KERNEL_SIZE - 1);
    localparam logic [ColW-1:0] ColMin  = ColW'(KERNEL_SIZE - 1);
    localparam logic [RowW-1:0] RowHalf = RowW'(KERNEL_SIZE / 2);
    localparam logic [ColW-1:0] ColHalf = ColW'(KERNEL_SIZE / 2);
    localparam logic [KW-1:0]   KLast   = KW'(NumCoef - 1);
    localparam logic [DW-1:0]   DLast   = DW'(DP_LAT);

    seq_state_e      state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [ColW-1:0] col_q, col_d;
    logic [KW-1:0]   kcnt_q, kcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            reload_q, reload_d;
    logic            kernel_loaded_q, kernel_loaded_d;

    logic            out_valid_q;
    logic [BITS-1:0] out_pixel_q;
    logic [RowW-1:0] out_row_q;
    logic [ColW-1:0] out_col_q;

    logic            coef_ready, pix_ready, dp_reset, kernel_we, shift_we;
    logic            tag_vld_in, tag_vld;
    logic [RowW-1:0] tag_row_in, tag_row;
    logic [ColW-1:0] tag_col_in, tag_col;

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        kcnt_d          = kcnt_q;
        dcnt_d          = dcnt_q;
        reload_d        = reload_q;
        kernel_loaded_d = kernel_loaded_q;
        coef_ready      = 1'b0;
        pix_ready       = 1'b0;
        dp_reset        = 1'b0;
        kernel_we       = 1'b0;
        shift_we        = 1'b0;
        tag_vld_in      = 1'b0;
        tag_row_in      = '0;
        tag_col_in      = '0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StClear;
                    reload_d = bus.kernel_reload | ~kernel_loaded_q;
                end
            end
            StClear: begin
                dp_reset = 1'b1;
                if (reload_q) begin
                    kernel_loaded_d = 1'b0;
                    state_d         = StLoadK;
                end else begin
                    state_d = StStream;
                end
            end
            StLoadK: begin
                coef_ready = 1'b1;
                if (bus.coef_valid) begin
                    kernel_we = 1'b1;
                    if (kcnt_q == KLast) begin
                        kcnt_d          = '0;
                        kernel_loaded_d = 1'b1;
                        state_d         = StStream;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                pix_ready = 1'b1;
                shift_we  = bus.pix_valid;
                if (bus.pix_valid) begin
                    // Only windows lying entirely inside the frame carry a valid tag.
                    if (row_q >= RowMin && col_q >= ColMin) begin
                        tag_vld_in = 1'b1;
                        tag_row_in = row_q - RowHalf;
                        tag_col_in = col_q - ColHalf;
                    end
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            dcnt_d  = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (dcnt_q == DLast) begin
                    dcnt_d  = '0;
                    state_d = StFinish;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            row_q           <= '0;
            col_q           <= '0;
            kcnt_q          <= '0;
            dcnt_q          <= '0;
            reload_q        <= 1'b0;
            kernel_loaded_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_pixel_q     <= '0;
            out_row_q       <= '0;
            out_col_q       <= '0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            kcnt_q          <= kcnt_d;
            dcnt_q          <= dcnt_d;
            reload_q        <= reload_d;
            kernel_loaded_q <= kernel_loaded_d;
            out_valid_q     <= tag_vld;
            out_pixel_q     <= bus.dp_pixel;
            out_row_q       <= tag_row;
            out_col_q       <= tag_col;
        end
    end

    conv_tag_pipe #(
        .Depth(DP_LAT),
        .RowW (RowW),
        .ColW (ColW)
    ) u_tag_pipe (
        .clk_i(clk_i),
        .clr_i(reset_i),
        .vld_i(tag_vld_in),
        .row_i(tag_row_in),
        .col_i(tag_col_in),
        .vld_o(tag_vld),
        .row_o(tag_row),
        .col_o(tag_col)
    );

    assign bus.coef_ready    = coef_ready;
    assign bus.pix_ready     = pix_ready;
    assign bus.dp_reset      = dp_reset;
    assign bus.dp_kernel_we  = kernel_we;
    assign bus.dp_kernel_in  = kernel_we ? bus.coef_data : '0;
    assign bus.dp_shift_we   = shift_we;
    assign bus.dp_img_in     = shift_we ? bus.pix_data : '0;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pixel     = out_pixel_q;
    assign bus.out_row       = out_row_q;
    assign bus.out_col       = out_col_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StFinish);
    assign bus.kernel_loaded = kernel_loaded_q;

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Controller that sequences the 3x3 convolution datapath (shift-register window, kernel memory, MAC/clip stage) for one image frame at a time.
- Runs the kernel-load phase, then streams pixels with a valid/ready handshake.
- Tracks row/column position so only windows lying fully inside the image are flagged valid, tagged with centre coordinates.
- Sits between the Wishbone/IO front end and the datapath; drives its write enables and datapath reset.

Parameters:
BITS, 9, pixel and kernel-coefficient width
KERNEL_SIZE, 3, kernel edge length; coefficient count = KERNEL_SIZE*KERNEL_SIZE
IMG_LENGTH, 128, pixels per image row
IMG_HEIGHT, 128, rows per frame
DP_LAT, 1, cycles from accepted pixel to datapath result at dp_pixel

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle frame start request; ignored unless state is IDLE
kernel_reload  input  1  sampled with start: 1 = load a new kernel first, 0 = reuse the loaded kernel
coef_valid  input  1  kernel coefficient offered
coef_data  input  BITS  signed coefficient
coef_ready  output  1  coefficient accepted this cycle when coef_valid && coef_ready
pix_valid  input  1  image pixel offered
pix_data  input  BITS  pixel, raster order
pix_ready  output  1  pixel accepted when pix_valid && pix_ready
dp_reset  output  1  datapath clear pulse
dp_kernel_we  output  1  to datapath kernel write enable
dp_kernel_in  output  BITS  to datapath kernel input
dp_shift_we  output  1  to datapath shift write enable
dp_img_in  output  BITS  to datapath image input
dp_pixel  input  BITS  datapath result
out_valid  output  1  out_pixel holds a full-window result
out_pixel  output  BITS  registered copy of dp_pixel
out_row  output  clog2(IMG_HEIGHT)  window-centre row
out_col  output  clog2(IMG_LENGTH)  window-centre column
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at frame end
kernel_loaded  output  1  a complete kernel is resident

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, tag pipeline cleared, kernel_loaded 0.
- States: IDLE, CLEAR, LOAD_K, STREAM, DRAIN, FINISH.
- IDLE -> CLEAR on start.
  - Registers reload = kernel_reload || !kernel_loaded.
- CLEAR lasts exactly 1 cycle with dp_reset=1.
  - If reload: clear kernel_loaded, go to LOAD_K. Otherwise go to STREAM.
  - dp_reset clears datapath kernel memory, so a no-reload frame depends on the datapath preserving its kernel across dp_reset. The datapath must accept dp_reset as a window-only clear.
- LOAD_K:
  - coef_ready=1.
  - Each coefficient handshake drives dp_kernel_we=1 and dp_kernel_in=coef_data combinationally; kcnt increments.
  - On the KERNEL_SIZE^2-th accept: set kernel_loaded=1, go to STREAM next cycle.
  - pix_ready=0 throughout.
- STREAM:
  - pix_ready=1; dp_shift_we=pix_valid; dp_img_in=pix_data.
  - No accept means no datapath write; the datapath must hold its window on stall.
  - On accept at (row, col): col increments; at IMG_LENGTH-1 it wraps to 0 and row increments.
  - Accept at row IMG_HEIGHT-1 / col IMG_LENGTH-1 -> DRAIN; pix_ready deasserts the following cycle.
- Window tag: an accept with row >= KERNEL_SIZE-1 and col >= KERNEL_SIZE-1 pushes {1, row-(KERNEL_SIZE/2), col-(KERNEL_SIZE/2)} into a DP_LAT-deep tag shift line. Any other accept pushes valid=0. The line advances every cycle, pushing 0 when there is no accept.
- The tag line head aligns with dp_pixel. out_valid, out_row, out_col and out_pixel are registered from the head, so end-to-end latency from accept to out_valid is DP_LAT+1 cycles.
- DRAIN waits DP_LAT+1 cycles for the tag line to empty, then goes to FINISH.
- FINISH: done=1 for 1 cycle, then IDLE.
- start while busy: ignored, no state change.
- Counter widths: clog2 of the bound. Coordinate subtraction never underflows because it is gated by the window condition.
- reset mid-frame: immediate return to IDLE. Tags are flushed, so no out_valid appears afterwards, and kernel_loaded clears.
- Simultaneous coef_valid and pix_valid: only the phase-appropriate handshake is accepted; the other ready stays 0.

Decomposition:
- Shared package `conv_pkg`: state encoding constants, KERNEL_SIZE/BITS defaults, and a clog2 function. Convolution-family blocks use this package.
- One natural sub-module, `conv_tag_pipe`: the DP_LAT-deep valid/row/col delay line with synchronous clear.

Test Plan:
1. IMG_LENGTH=8, IMG_HEIGHT=4, DP_LAT=1, start with kernel_reload=1, 9 coefficients back-to-back, 32 pixels with no stalls.
   - Required: exactly 12 out_valid pulses.
   - First pulse reports (row,col)=(1,1), 2 cycles after accept of pixel (2,2); last pulse reports (2,6).
   - done fires 2+1 cycles after the last accept.
2. Kernel identity (centre=1, rest 0), pixel value = row*8+col.
   - out_pixel equals out_row*8+out_col on every valid output.
3. Random pix_valid stalls of about 30%.
   - dp_shift_we matches accepts exactly; same 12 outputs in the same order as scenario 1.
4. Second frame with kernel_reload=0.
   - No LOAD_K phase: coef_ready stays 0, and STREAM is entered 2 cycles after start.
5. Assert reset after 10 accepted pixels.
   - busy=0 next cycle; no out_valid afterwards; kernel_loaded=0.
   - A following start with kernel_reload=0 still enters LOAD_K.
6. Pulse start during STREAM and drive coef_valid=1 during STREAM.
   - Both are ignored; coef_ready=0; output count is unchanged at 12.
